// File: rtl/uart_transmitter_if.sv
// Host-side byte handshake for uart_transmitter: data plus valid/ready.
// The master drives bytes in; the slave (the transmitter) reports FIFO space.
interface uart_transmitter_if;
  logic [0:7] i_data;
  logic       i_valid;
  logic       o_ready;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// FIFO-buffered asynchronous serial transmitter, 8 data bits, 1 or 2 stop bits, idle-high.
// Bytes are pushed over the valid/ready interface and framed back-to-back while the FIFO holds data.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 21813,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          i_reset,
  uart_transmitter_if.slave             bus_if,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(FIFO_DEPTH);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [0:7]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;

  // Serialiser state
  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_next;
  logic [0:7]      r_shift;
  logic [0:7]      w_shift_next;
  logic            r_tx;
  logic            w_tx_next;

  logic            w_push;
  logic            w_pop;
  logic            w_fifo_empty;
  logic            w_bit_end;

  assign bus_if.o_ready = !i_reset && (r_count < DEPTH_C);
  assign w_push         = bus_if.i_valid && bus_if.o_ready;
  assign w_fifo_empty   = (r_count == '0);
  assign w_bit_end      = (r_cnt == CNT_LAST);

  assign o_tx         = r_tx;
  assign o_busy       = (r_state != S_IDLE);
  assign o_fifo_count = r_count;

  // Full/empty come from the occupancy count, so the pointers may simply wrap.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values, regardless of statement order.
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count makes stale entries unreachable, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus_if.i_data;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves one unassigned (which would infer a latch).
    w_state_next   = r_state;
    w_cnt_next     = w_bit_end ? '0 : r_cnt + CW'(1);
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        w_tx_next  = 1'b1;
        if (!w_fifo_empty) begin
          w_pop          = 1'b1;
          w_shift_next   = r_mem[r_rd_ptr];
          w_state_next   = S_START;
          w_tx_next      = 1'b0;
          w_bit_idx_next = '0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_next   = S_DATA;
          w_tx_next      = r_shift[0];
          w_bit_idx_next = '0;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next   = S_STOP;
            w_tx_next      = 1'b1;
            w_bit_idx_next = '0;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[r_bit_idx + 3'd1];
          end
        end
      end

      // The bit index doubles as the stop-bit counter, keeping the cycle counter one bit-period wide.
      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit_idx == STOP_LAST) begin
            w_bit_idx_next = '0;
            if (!w_fifo_empty) begin
              w_pop        = 1'b1;
              w_shift_next = r_mem[r_rd_ptr];
              w_state_next = S_START;
              w_tx_next    = 1'b0;
            end else begin
              w_state_next = S_IDLE;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

endmodule
